// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative RV32M multiply/divide unit.
//
// A request is accepted on the in_valid/in_ready handshake. Operands are
// reduced to magnitudes and the result sign is recorded. A radix-2 loop
// then runs for WIDTH cycles: shift-add for multiply, restoring
// shift-subtract for divide. The signed result is held on the
// out_valid/out_ready handshake until the consumer takes it.
//
// Optional feature macro: ALU_MULDIV_DIV_EN
//   defined   : the divider and the divide special cases are built.
//   undefined : ops 100-111 complete in one cycle with res=0, div_zero=1.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   op[2:0]             RV32M funct3
//   srcA, srcB          rs1 / rs2 operands
//   kill                synchronous abort of the operation in flight
//   out_valid/out_ready result handshake
//   res                 registered result
//   div_zero            result came from a divide by zero
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

`ifdef ALU_MULDIV_DIV_EN
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Two's-complement negation at operand width
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation at product width
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    neg_2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of v when it is treated as signed, otherwise v unchanged
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      mag = neg_w(v);
    end else begin
      mag = v;
    end
  endfunction

  logic [1:0]         r_state;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_b;      // multiplicand magnitude or divisor magnitude
  logic               r_neg;    // the final result must be negated
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;    // {high/remainder, low/quotient}
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_res;
  logic               r_div_zero;

  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_neg;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_calc_res;
  logic               w_spec;
  logic [WIDTH-1:0]   w_spec_res;
  logic               w_spec_dz;
  logic               w_accept;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign div_zero  = r_div_zero;

  assign w_accept = in_valid && r_in_ready && !kill;

  // Operand signedness and the result sign for the incoming op
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    w_neg      = 1'b0;
    case (op)
      OP_MUL:    begin w_a_signed = 1'b0; w_b_signed = 1'b0; w_neg = 1'b0; end
      OP_MULH:   begin w_a_signed = 1'b1; w_b_signed = 1'b1; w_neg = srcA[WIDTH-1] ^ srcB[WIDTH-1]; end
      OP_MULHSU: begin w_a_signed = 1'b1; w_b_signed = 1'b0; w_neg = srcA[WIDTH-1]; end
      OP_MULHU:  begin w_a_signed = 1'b0; w_b_signed = 1'b0; w_neg = 1'b0; end
      OP_DIV:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; w_neg = srcA[WIDTH-1] ^ srcB[WIDTH-1]; end
      OP_DIVU:   begin w_a_signed = 1'b0; w_b_signed = 1'b0; w_neg = 1'b0; end
      // The remainder takes the dividend's sign
      OP_REM:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; w_neg = srcA[WIDTH-1]; end
      OP_REMU:   begin w_a_signed = 1'b0; w_b_signed = 1'b0; w_neg = 1'b0; end
      default:   begin w_a_signed = 1'b0; w_b_signed = 1'b0; w_neg = 1'b0; end
    endcase
  end

`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_next;

  // Restoring divide step: try to subtract the divisor from the shifted remainder
  always_comb begin
    w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    if (w_trial[WIDTH]) begin
      w_div_next = {r_acc[2*WIDTH-2:0], 1'b0};
    end else begin
      w_div_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  // Divide-by-zero and signed-overflow cases bypass the iterative loop
  always_comb begin
    w_spec     = 1'b0;
    w_spec_res = ZERO_W;
    w_spec_dz  = 1'b0;
    if (op[2] && (srcB == ZERO_W)) begin
      w_spec     = 1'b1;
      w_spec_res = op[1] ? srcA : ONES_W;
      w_spec_dz  = 1'b1;
    end else if (op[2] && !op[0] && (srcA == MIN_W) && (srcB == ONES_W)) begin
      w_spec     = 1'b1;
      w_spec_res = op[1] ? ZERO_W : MIN_W;
      w_spec_dz  = 1'b0;
    end else begin
      w_spec     = 1'b0;
      w_spec_res = ZERO_W;
      w_spec_dz  = 1'b0;
    end
  end
`else
  // Without the divider every divide-class op completes at once with div_zero set
  always_comb begin
    w_spec     = op[2];
    w_spec_res = ZERO_W;
    w_spec_dz  = 1'b1;
  end
`endif

  // One iteration of the active loop and the signed result formed from it
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {1'b0, ZERO_W});
`ifdef ALU_MULDIV_DIV_EN
    if (r_op[2]) begin
      w_step = w_div_next;
    end else begin
      w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
`else
    w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
`endif
    w_prod     = r_neg ? neg_2w(w_step) : w_step;
    w_calc_res = ZERO_W;
    if (!r_op[2]) begin
      w_calc_res = (r_op == OP_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    end else if (r_op[1]) begin
      w_calc_res = r_neg ? neg_w(w_step[2*WIDTH-1:WIDTH]) : w_step[2*WIDTH-1:WIDTH];
    end else begin
      w_calc_res = r_neg ? neg_w(w_step[WIDTH-1:0]) : w_step[WIDTH-1:0];
    end
  end

  // Control FSM, loop datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 3'b000;
      r_b         <= ZERO_W;
      r_neg       <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_acc       <= {(2*WIDTH){1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_res       <= ZERO_W;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= op;
            r_b        <= mag(srcB, w_b_signed);
            r_neg      <= w_neg;
            r_cnt      <= CNT_INIT;
            r_acc      <= {ZERO_W, mag(srcA, w_a_signed)};
            r_in_ready <= 1'b0;
            if (w_spec) begin
              r_state     <= S_DONE;
              r_res       <= w_spec_res;
              r_div_zero  <= w_spec_dz;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_CALC;
            end
          end else begin
            // Also raises in_ready on the first edge after reset
            r_in_ready <= 1'b1;
          end
        end
        S_CALC: begin
          if (kill) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              r_state     <= S_DONE;
              r_res       <= w_calc_res;
              r_div_zero  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_DONE: begin
          if (kill || out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed testbench for alu_muldiv at WIDTH=32. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [31:0] srcA = 32'h0;
  logic [31:0] srcB = 32'h0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        div_zero;

  int vectors = 0;
  int miscompares = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .srcA(srcA), .srcB(srcB), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for its result; cyc counts cycles after acceptance
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic d, output int cyc);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    r = res;
    d = div_zero;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, div_zero} !== 3'b000 || res !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b div_zero=%b res=%h, required 0/0/0/0",
               in_ready, out_valid, div_zero, res);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'b000, 3'b010, 3'b011, 3'b001};
    logic [31:0] as  [4] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000};
    logic [31:0] r;
    logic d;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], r, d, cyc);
      vectors++;
      if (r !== exp[i] || d !== 1'b0 || cyc !== 33) begin
        miscompares++;
        $display("FAIL mul_%0d op=%b: res=%h dz=%b latency=%0d, required res=%h dz=0 latency=33",
                 i, ops[i], r, d, cyc, exp[i]);
      end
      take_result();
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
`ifdef ALU_MULDIV_DIV_EN
    logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    logic        edz = 1'b0;
    int          elat = 33;
`else
    logic [31:0] exp [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic        edz = 1'b1;
    int          elat = 1;
`endif
    logic [31:0] r;
    logic d;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], r, d, cyc);
      vectors++;
      if (r !== exp[i] || d !== edz || cyc !== elat) begin
        miscompares++;
        $display("FAIL div_%0d op=%b: res=%h dz=%b latency=%0d, required res=%h dz=%b latency=%0d",
                 i, ops[i], r, d, cyc, exp[i], edz, elat);
      end
      take_result();
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'd5, 32'h00001234, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
`ifdef ALU_MULDIV_DIV_EN
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h00001234, 32'h80000000, 32'h0};
    logic        edz [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
    logic [31:0] exp [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic        edz [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    logic [31:0] r;
    logic d;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], r, d, cyc);
      vectors++;
      if (r !== exp[i] || d !== edz[i] || cyc !== 1) begin
        miscompares++;
        $display("FAIL special_%0d op=%b: res=%h dz=%b latency=%0d, required res=%h dz=%b latency=1",
                 i, ops[i], r, d, cyc, exp[i], edz[i]);
      end
      take_result();
    end
  endtask

  task automatic test_hold();
    logic [31:0] r;
    logic d;
    int cyc;
    do_op(3'b000, 32'd5, 32'd6, r, d, cyc);
    vectors++;
    if (r !== 32'd30 || cyc !== 33) begin
      miscompares++;
      $display("FAIL hold_result: res=%h latency=%0d, required res=0000001e latency=33", r, cyc);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (res !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle_%0d: res=%h out_valid=%b in_ready=%b, required 0000001e/1/0",
                 i, res, out_valid, in_ready);
      end
    end
    take_result();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_kill();
    bit seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
    op = 3'b100;
`else
    op = 3'b011;
`endif
    srcA = 32'd100; srcB = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 32'd30) begin
      miscompares++;
      $display("FAIL kill_calc: in_ready=%b out_valid=%b res=%h, required 1/0/0000001e",
               in_ready, out_valid, res);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_no_result: out_valid seen=%b, required 0", seen);
    end
    // kill in IDLE blocks a concurrent request
    in_valid = 1'b1; op = 3'b000; srcA = 32'd2; srcB = 32'd2; kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_idle: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic d;
    int cyc;
    in_valid = 1'b1; op = 3'b000; srcA = 32'd9; srcB = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, div_zero} !== 3'b000 || res !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b div_zero=%b res=%h, required 0/0/0/0",
               in_ready, out_valid, div_zero, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'b000, 32'd3, 32'd4, r, d, cyc);
    vectors++;
    if (r !== 32'd12 || d !== 1'b0 || cyc !== 33) begin
      miscompares++;
      $display("FAIL mul_after_reset: res=%h dz=%b latency=%0d, required 0000000c/0/33", r, d, cyc);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_hold();
    test_kill();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative multiply/divide unit extending the datapath ALU with the RV32M operations, parametrised in operand width. It sits beside the single-cycle ALU in the execute stage. Operands are accepted on a valid/ready handshake and computed with a radix-2 shift-add or shift-subtract loop. The result is held on an output handshake until the consumer takes it.

## Interface
- `WIDTH`, default 32: operand and result width; must be even and ≥ 4.
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit can accept a request; high only in IDLE.
- `op` input 3: RV32M funct3 encoding:
  - 000 MUL
  - 001 MULH
  - 010 MULHSU
  - 011 MULHU
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- `srcA` input WIDTH: rs1 operand (multiplicand or dividend).
- `srcB` input WIDTH: rs2 operand (multiplier or divisor).
- `kill` input 1: synchronous abort of the operation in flight.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `res` output WIDTH: result.
- `div_zero` output 1: result came from a divide or remainder by zero; qualified by `out_valid`.

## Operation
- States: IDLE, CALC, DONE.
- Reset values: state IDLE; `in_ready`=1 after reset, low during reset; `out_valid`=0; `res`=0; `div_zero`=0; internal counter, accumulator and registered operands all 0.
- IDLE → CALC on handshake (`in_valid && in_ready`). At that edge the unit latches `op` and the magnitudes of `srcA`/`srcB` according to signedness, records the result sign, and loads counter=WIDTH.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: `srcA` signed, `srcB` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: sign-agnostic; low half only.
- Multiply:
  - 2·WIDTH accumulator; one shift-add step per CALC cycle.
  - The final product is negated if the sign flag is set.
  - MUL returns the low WIDTH bits; MULH* return the high WIDTH bits.
- Divide:
  - Restoring algorithm; one quotient bit per CALC cycle.
  - Quotient is negated when the operand signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Special cases (IDLE → DONE directly, skipping CALC):
  - Divisor 0: DIV/DIVU `res`=all ones, REM/REMU `res`=`srcA`, `div_zero`=1.
  - Signed overflow (DIV/REM with `srcA`=most-negative and `srcB`=−1): DIV `res`=most-negative, REM `res`=0, `div_zero`=0.
- CALC decrements the counter each cycle. When the counter reaches 1, CALC → DONE and `res`/`div_zero` are registered.
- DONE: `out_valid`=1 and `res` stable until `out_ready` is sampled high. Then DONE → IDLE and `out_valid` clears at that edge.
- `kill` in CALC or DONE forces IDLE and clears `out_valid`; `res` keeps its last value. `kill` in IDLE has no effect, and any concurrent `in_valid` is not accepted that cycle.
- Reset asserted mid-operation returns all state to reset values immediately, with no partial result.

## Timing
- Request accepted at edge N.
- Normal ops:
  - CALC occupies cycles N+1 … N+WIDTH.
  - `out_valid` is high from cycle N+WIDTH+1.
  - Latency is WIDTH+1 cycles, independent of operand values.
- Special-case divides: `out_valid` is high from cycle N+1.
- Throughput:
  - With `out_ready` tied high: one op per WIDTH+2 cycles.
  - With `out_ready` high and special cases: one op per 2 cycles.
- `in_ready` is low from edge N until the edge where DONE is left. There is no back-to-back acceptance in the same cycle as `out_ready`.
- `res` and `div_zero` change only on entry to DONE, and are registered (no combinational path from inputs).

## Configuration
- `ALU_MULDIV_DIV_EN`
  - Defined: all eight ops implemented as above.
  - Undefined: divider datapath and special-case logic are removed. Ops 100–111 go IDLE → DONE in one cycle with `res`=0 and `div_zero`=1. Multiply behaviour and timing are unchanged.

## Test plan
- MUL, WIDTH=32, `srcA`=7, `srcB`=−3 (0xFFFFFFFD) → `res`=0xFFFFFFEB, `out_valid` exactly 33 cycles after acceptance.
- MULHSU with `srcA`=−1, `srcB`=0xFFFFFFFF → `res`=0xFFFFFFFF; MULHU with the same operands → 0xFFFFFFFE; MULH with the same operands → 0x00000000.
- DIV −7/2 → `res`=0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → `res`=0xFFFFFFFF, `div_zero`=1, `out_valid` 1 cycle after acceptance; DIV 0x80000000/−1 → 0x80000000, `div_zero`=0.
- Hold `out_ready`=0 for 10 cycles in DONE → `res` and `out_valid` stable and `in_ready`=0 throughout; after `out_ready`=1 for one edge → IDLE, `in_ready`=1.
- Pulse `kill` at cycle N+10 of a DIV → IDLE next cycle, `out_valid` never asserts. Drop `rst_n` mid-CALC → outputs return to reset values asynchronously. Then a new MUL 3×4 → 12.
